// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester round-robin arbiter with locked bursts for one Block_RAM
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [3:0]            m0_be,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [3:0]            m1_be,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t                state, state_nxt;
    logic                  prio, prio_nxt;          // 0: M0 wins contention, 1: M1 wins
    logic [3:0]            burst_cnt, burst_nxt;
    logic [1:0]            rd_tag;                  // bit0: M0 read in flight, bit1: M1 read in flight
    logic [ADDR_WIDTH-1:0] addra_q, addrb_q;
    logic [31:0]           dina_q;
    logic                  gnt0, gnt1;

    // Grant decision and arbitration next-state from current requests and ownership
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        prio_nxt  = prio;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || !prio)) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    // the requester just served loses priority to the other one
                    prio_nxt = gnt0;
                    if (MAX_BURST > 1 && ((gnt0 && m0_lock) || (gnt1 && m1_lock))) begin
                        state_nxt = gnt0 ? OWN0 : OWN1;
                        burst_nxt = 4'd1;
                    end
                end
            end
            OWN0: begin
                gnt0 = m0_req;
                if (gnt0) begin
                    if (!m0_lock || (burst_cnt + 4'd1) >= MAX_B) begin
                        state_nxt = IDLE;
                        prio_nxt  = 1'b1;
                        burst_nxt = 4'd0;
                    end else begin
                        burst_nxt = burst_cnt + 4'd1;
                    end
                end else if (!m0_lock) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                    burst_nxt = 4'd0;
                end
            end
            OWN1: begin
                gnt1 = m1_req;
                if (gnt1) begin
                    if (!m1_lock || (burst_cnt + 4'd1) >= MAX_B) begin
                        state_nxt = IDLE;
                        prio_nxt  = 1'b0;
                        burst_nxt = 4'd0;
                    end else begin
                        burst_nxt = burst_cnt + 4'd1;
                    end
                end else if (!m1_lock) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                    burst_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = 4'd0;
            end
        endcase
    end

    // Grants are forced low while reset is held so outputs show reset values immediately
    assign m0_gnt = gnt0 && !rst;
    assign m1_gnt = gnt1 && !rst;

    // RAM port steering: granted access drives the port, otherwise the last value is held
    always_comb begin
        ram_wea   = 4'b0;
        ram_addra = addra_q;
        ram_dina  = dina_q;
        ram_addrb = addrb_q;
        if (m0_gnt) begin
            if (m0_we) begin
                ram_addra = m0_addr;
                ram_dina  = m0_wdata;
                ram_wea   = m0_be;
            end else begin
                ram_addrb = m0_addr;
            end
        end else if (m1_gnt) begin
            if (m1_we) begin
                ram_addra = m1_addr;
                ram_dina  = m1_wdata;
                ram_wea   = m1_be;
            end else begin
                ram_addrb = m1_addr;
            end
        end
    end

    // State, held RAM port values and the read-return tag
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            burst_cnt <= 4'd0;
            rd_tag    <= 2'b00;
            addra_q   <= '0;
            addrb_q   <= '0;
            dina_q    <= '0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            burst_cnt <= burst_nxt;
            rd_tag    <= {m1_gnt && !m1_we, m0_gnt && !m0_we};
            addra_q   <= ram_addra;
            addrb_q   <= ram_addrb;
            dina_q    <= ram_dina;
        end
    end

    // Read data returns one cycle after the read grant, only to the requester that issued it
    assign m0_rvalid = rd_tag[0];
    assign m1_rvalid = rd_tag[1];
    assign m0_rdata  = rd_tag[0] ? ram_doutb : 32'd0;
    assign m1_rdata  = rd_tag[1] ? ram_doutb : 32'd0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter with Block_RAM model
module tb_bram_port_arbiter;

    localparam int AW = 14;
    localparam int MB = 4;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    logic [1:0]    req, lock, we;
    logic [3:0]    be    [2];
    logic [AW-1:0] addr  [2];
    logic [31:0]   wdata [2];

    logic [1:0]    s_req, s_lock, s_we;
    logic [3:0]    s_be    [2];
    logic [AW-1:0] s_addr  [2];
    logic [31:0]   s_wdata [2];

    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata, ram_dina;
    logic [3:0]    ram_wea;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_doutb = 32'd0;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clka(clka), .rst(rst),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_be(be[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_be(be[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // Block_RAM stand-in: byte-enabled write port, registered read port
    logic [31:0] ram_mem [0:63] = '{default: 32'd0};
    always @(posedge clka) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) ram_mem[ram_addra[5:0]][8*b +: 8] <= ram_dina[8*b +: 8];
        ram_doutb <= ram_mem[ram_addrb[5:0]];
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [1:0]    gnt;
        logic [3:0]    wea;
        logic [AW-1:0] addra;
        logic [31:0]   dina;
        logic [AW-1:0] addrb;
    } exp_t;
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   glog[$];
    int   checks = 0;
    int   passes = 0;
    int   wea_cnt = 0;
    logic [31:0] last_rdata = 32'd0;

    // reference model: ownership, burst length, fairness pointer, memory image
    int            own = -1;
    int            cnt = 0;
    int            prio = 0;
    logic [AW-1:0] last_wa = '0, last_ra = '0;
    logic [1:0]    pend = 2'b00;
    logic [31:0]   ref_mem [0:63] = '{default: 32'd0};

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endfunction

    // monitor: pops expectations whenever the DUT presents a cycle's outputs
    always @(negedge clka) begin
        exp_t e;
        rd_t  r;
        if (rst) begin
            chk("reset_ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wea, ram_addra, ram_addrb}, 64'd0);
            chk("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
            chk("reset_dina", ram_dina, 64'd0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("gnt", {m1_gnt, m0_gnt}, e.gnt);
                chk("ram_wea", ram_wea, e.wea);
                chk("ram_addra", ram_addra, e.addra);
                chk("ram_addrb", ram_addrb, e.addrb);
                if (e.wea != 4'd0) chk("ram_dina", ram_dina, e.dina);
                glog.push_back(m0_gnt ? 0 : (m1_gnt ? 1 : -1));
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                chk("rvalid", {m1_rvalid, m0_rvalid}, (r.id == 0) ? 2'b01 : 2'b10);
                chk("rdata", (r.id == 0) ? m0_rdata : m1_rdata, r.data);
                chk("rdata_other", (r.id == 0) ? m1_rdata : m0_rdata, 32'd0);
                last_rdata = (r.id == 0) ? m0_rdata : m1_rdata;
            end else begin
                chk("rvalid_idle", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}, 64'd0);
            end
            if (ram_wea != 4'd0) wea_cnt++;
        end
    end

    task automatic set_stage(input int i, input logic r, input logic l, input logic w,
                             input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
        s_req[i] = r; s_lock[i] = l; s_we[i] = w; s_be[i] = b; s_addr[i] = a; s_wdata[i] = d;
    endtask

    task automatic idle_stage();
        set_stage(0, 0, 0, 0, 4'h0, '0, 32'd0);
        set_stage(1, 0, 0, 0, 4'h0, '0, 32'd0);
    endtask

    // mode 0: fully random requests; mode 1: both always request reads, no lock
    task automatic next_stage(input int mode);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i]) begin
                if (mode == 0)
                    set_stage(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              AW'($urandom_range(0, 63)), $urandom);
                else
                    set_stage(i, 1, 0, 0, 4'h0, AW'($urandom_range(0, 63)), 32'd0);
            end
        end
    endtask

    // apply staged inputs for one cycle and record what the spec rules say must happen
    task automatic cycle();
        int   g;
        exp_t e;
        rd_t  r;
        @(posedge clka); #1;
        req = s_req; lock = s_lock; we = s_we;
        for (int i = 0; i < 2; i++) begin
            be[i] = s_be[i]; addr[i] = s_addr[i]; wdata[i] = s_wdata[i];
        end
        g = -1;
        if (own < 0) begin
            if (req[0] && (!req[1] || prio == 0)) g = 0;
            else if (req[1]) g = 1;
        end else if (req[own]) begin
            g = own;
        end
        e.cyc  = cyc;
        e.gnt  = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
        e.wea  = 4'd0;
        e.dina = 32'd0;
        if (g >= 0) begin
            if (we[g]) begin
                last_wa = addr[g];
                e.wea   = be[g];
                e.dina  = wdata[g];
                for (int b = 0; b < 4; b++)
                    if (be[g][b]) ref_mem[addr[g][5:0]][8*b +: 8] = wdata[g][8*b +: 8];
            end else begin
                last_ra = addr[g];
                r.due  = cyc + 1;
                r.id   = g;
                r.data = ref_mem[addr[g][5:0]];
                rd_q.push_back(r);
            end
        end
        e.addra = last_wa;
        e.addrb = last_ra;
        exp_q.push_back(e);
        if (own < 0) begin
            if (g >= 0) begin
                prio = 1 - g;
                if (lock[g] && MB > 1) begin own = g; cnt = 1; end
            end
        end else if (g == own) begin
            cnt++;
            if (!lock[g] || cnt >= MB) begin own = -1; prio = 1 - g; cnt = 0; end
        end else if (!lock[own]) begin
            prio = 1 - own; own = -1; cnt = 0;
        end
        for (int i = 0; i < 2; i++) pend[i] = req[i] && (g != i);
    endtask

    task automatic do_reset(input int n);
        @(posedge clka); #1;
        rst = 1'b1;
        idle_stage();
        req = 2'b00; lock = 2'b00; we = 2'b00;
        exp_q.delete(); rd_q.delete();
        own = -1; cnt = 0; prio = 0; last_wa = '0; last_ra = '0; pend = 2'b00;
        repeat (n) @(posedge clka);
        #1 rst = 1'b0;
        glog.delete();
    endtask

    task automatic settle();
        @(negedge clka); #1;
    endtask

    task automatic check_log(input string name, input int ex[$]);
        chk({name, "_len"}, glog.size(), ex.size());
        for (int k = 0; k < ex.size() && k < glog.size(); k++)
            chk($sformatf("%s[%0d]", name, k), glog[k], ex[k]);
    endtask

    int t3_req [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int t3_addr[9] = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h34, 'h35, 'h35, 'h35};

    initial begin
        req = 2'b00; lock = 2'b00; we = 2'b00;
        for (int i = 0; i < 2; i++) begin be[i] = '0; addr[i] = '0; wdata[i] = '0; end
        idle_stage();
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        glog.delete();

        // M0 alone: full write then readback
        set_stage(0, 1, 0, 1, 4'hF, AW'('h010), 32'hDEADBEEF); cycle();
        set_stage(0, 1, 0, 0, 4'h0, AW'('h010), 32'd0);        cycle();
        idle_stage(); cycle(); cycle();
        settle();
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        check_log("t1_gnt", '{0, 0, -1, -1});

        // M1 locked burst capped at MAX_BURST while M0 keeps asking
        glog.delete();
        for (int k = 0; k < 9; k++) begin
            set_stage(0, 1, 0, 0, 4'h0, AW'('h005), 32'd0);
            set_stage(1, t3_req[k] != 0, t3_req[k] != 0, 0, 4'h0, AW'(t3_addr[k]), 32'd0);
            cycle();
        end
        idle_stage(); cycle();
        settle();
        check_log("t3_gnt", '{1, 1, 1, 1, 0, 1, 1, -1, 0, -1});

        // partial byte write over a preloaded word
        set_stage(0, 1, 0, 1, 4'hF, AW'('h020), 32'h11223344); cycle();
        settle();
        wea_cnt = 0;
        set_stage(0, 1, 0, 1, 4'b0010, AW'('h020), 32'hAABBCCDD); cycle();
        set_stage(0, 1, 0, 0, 4'h0, AW'('h020), 32'd0);          cycle();
        idle_stage(); cycle(); cycle();
        settle();
        chk("t4_rdata", last_rdata, 32'h1122CC44);
        chk("t4_wea_cycles", wea_cnt, 1);

        // M0 drops req with lock low mid-burst, M1 waiting
        glog.delete();
        set_stage(0, 1, 1, 0, 4'h0, AW'('h010), 32'd0); cycle();
        set_stage(1, 1, 0, 0, 4'h0, AW'('h020), 32'd0);
        set_stage(0, 1, 1, 0, 4'h0, AW'('h011), 32'd0); cycle();
        set_stage(0, 0, 0, 0, 4'h0, AW'('h011), 32'd0); cycle();
        cycle();
        idle_stage(); cycle();
        settle();
        check_log("t6_gnt", '{0, 0, -1, 1, -1});

        // reset right after a read grant inside a locked burst
        set_stage(0, 1, 1, 0, 4'h0, AW'('h010), 32'd0); cycle();
        set_stage(0, 1, 1, 0, 4'h0, AW'('h020), 32'd0); cycle();
        do_reset(2);

        // both request reads every cycle from reset: strict alternation starting with M0
        for (int k = 0; k < 8; k++) begin next_stage(1); cycle(); end
        idle_stage(); pend = 2'b00; cycle();
        settle();
        check_log("t2_gnt", '{0, 1, 0, 1, 0, 1, 0, 1, -1});

        // randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin next_stage(0); cycle(); end
        idle_stage(); cycle();
        // release any burst still held idle by a locked owner
        cycle(); cycle();
        settle();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
